// File: rtl/cache_nway_pkg.sv
// Shared types and width helpers for the N-way set-associative cache array.
// Defaults match the 64-set, 2-way, 4-word configuration.
package cache_nway_pkg;

  localparam int DEF_SETS  = 64;
  localparam int DEF_WAYS  = 2;
  localparam int DEF_WORDS = 4;
  localparam int DEF_TAG_W = 24;

  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } req_e;

  typedef struct packed {
    logic                       valid;
    logic                       dirty;
    logic [DEF_TAG_W-1:0]       tag;
    logic [DEF_WORDS-1:0][31:0] data;
  } line_t;

  function automatic int way_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lru_tracker.sv
// True-LRU age tracking per set; age 0 is MRU, NUM_WAYS-1 is LRU.
// Ages reset to the way number so every set starts as a valid permutation.
module lru_tracker
  import cache_nway_pkg::*;
#(
  parameter int NUM_SETS = DEF_SETS,
  parameter int NUM_WAYS = DEF_WAYS,
  localparam int INDEX_W = $clog2(NUM_SETS),
  localparam int WAY_W   = way_w(NUM_WAYS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_touch,
  input  logic [INDEX_W-1:0] i_set,
  input  logic [WAY_W-1:0]   i_way,
  output logic [WAY_W-1:0]   o_lru_way
);

  if (NUM_WAYS == 1) begin : g_dm
    assign o_lru_way = '0;
  end else begin : g_lru
    localparam int AGE_W = $clog2(NUM_WAYS);

    logic [AGE_W-1:0] r_age [NUM_SETS][NUM_WAYS];
    logic [WAY_W-1:0] w_lru;

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int s = 0; s < NUM_SETS; s++)
          for (int w = 0; w < NUM_WAYS; w++)
            r_age[s][w] <= AGE_W'(w);
      end else if (i_touch) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (WAY_W'(w) == i_way)
            r_age[i_set][w] <= '0;
          else if (r_age[i_set][w] < r_age[i_set][i_way])
            r_age[i_set][w] <= r_age[i_set][w] + 1'b1;
        end
      end
    end

    always_comb begin
      w_lru = '0;
      for (int w = 0; w < NUM_WAYS; w++)
        if (r_age[i_set][w] == AGE_W'(NUM_WAYS - 1))
          w_lru = WAY_W'(w);
    end

    assign o_lru_way = w_lru;
  end

endmodule

// File: rtl/cache_memory_nway.sv
// N-way set-associative cache array: lookup, write-hit update,
// victim selection with dirty eviction output, and refill.
module cache_memory_nway
  import cache_nway_pkg::*;
#(
  parameter int NUM_SETS      = DEF_SETS,
  parameter int NUM_WAYS      = DEF_WAYS,
  parameter int WORDS_PER_BLK = DEF_WORDS,
  parameter int TAG_W         = DEF_TAG_W,
  localparam int INDEX_W  = $clog2(NUM_SETS),
  localparam int OFFSET_W = $clog2(WORDS_PER_BLK),
  localparam int BLOCK_W  = 32 * WORDS_PER_BLK,
  localparam int WAY_W    = way_w(NUM_WAYS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [TAG_W-1:0]    i_tag,
  input  logic [INDEX_W-1:0]  i_index,
  input  logic [OFFSET_W-1:0] i_blk_offset,
  input  logic                i_req_type,
  input  logic                i_read_en_cache,
  input  logic                i_write_en_cache,
  input  logic                i_refill,
  input  logic [BLOCK_W-1:0]  i_data_in_mem,
  input  logic [31:0]         i_data_in,
  output logic                o_resp_valid,
  output logic                o_hit,
  output logic [31:0]         o_data_out,
  output logic                o_dirty_bit,
  output logic [BLOCK_W-1:0]  o_dirty_block_out,
  output logic [TAG_W-1:0]    o_victim_tag
);

  logic             r_valid [NUM_SETS][NUM_WAYS];
  logic             r_dirty [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0] r_tag   [NUM_SETS][NUM_WAYS];
  logic [31:0]      r_data  [NUM_SETS][NUM_WAYS][WORDS_PER_BLK];
  logic [WAY_W-1:0] r_victim_way_q;
  logic             r_pending_q;

  logic               w_lookup, w_fill, w_merge;
  logic               w_hit, w_inv_found;
  logic [WAY_W-1:0]   w_hit_way, w_inv_way;
  logic [WAY_W-1:0]   w_lru_way, w_victim;
  logic [WAY_W-1:0]   w_touch_way;
  logic               w_touch;
  logic [31:0]        w_hit_word;
  logic [BLOCK_W-1:0] w_victim_blk;

  assign w_lookup = (i_read_en_cache | i_write_en_cache) & ~i_refill;
  assign w_fill   = i_refill & i_write_en_cache & r_pending_q;
  assign w_merge  = req_e'(i_req_type) == REQ_WRITE;

  always_comb begin
    w_hit       = 1'b0;
    w_hit_way   = '0;
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!w_hit && r_valid[i_index][w] &&
          r_tag[i_index][w] == i_tag) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
      if (!w_inv_found && !r_valid[i_index][w]) begin
        w_inv_found = 1'b1;
        w_inv_way   = WAY_W'(w);
      end
    end
  end

  assign w_victim    = w_inv_found ? w_inv_way : w_lru_way;
  assign w_touch     = w_fill | (w_lookup & w_hit);
  assign w_touch_way = w_fill ? r_victim_way_q : w_hit_way;
  assign w_hit_word  = r_data[i_index][w_hit_way][i_blk_offset];

  always_comb begin
    w_victim_blk = '0;
    for (int k = 0; k < WORDS_PER_BLK; k++)
      w_victim_blk[32*k +: 32] = r_data[i_index][w_victim][k];
  end

  lru_tracker #(
    .NUM_SETS (NUM_SETS),
    .NUM_WAYS (NUM_WAYS)
  ) u_lru (
    .clk       (clk),
    .rst       (rst),
    .i_touch   (w_touch),
    .i_set     (i_index),
    .i_way     (w_touch_way),
    .o_lru_way (w_lru_way)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++) begin
          r_valid[s][w] <= 1'b0;
          r_dirty[s][w] <= 1'b0;
        end
      r_victim_way_q    <= '0;
      r_pending_q       <= 1'b0;
      o_resp_valid      <= 1'b0;
      o_hit             <= 1'b0;
      o_data_out        <= '0;
      o_dirty_bit       <= 1'b0;
      o_dirty_block_out <= '0;
      o_victim_tag      <= '0;
    end else begin
      o_resp_valid <= w_lookup;
      if (w_fill) begin
        r_valid[i_index][r_victim_way_q] <= 1'b1;
        r_dirty[i_index][r_victim_way_q] <= w_merge;
        r_pending_q <= 1'b0;
      end else if (w_lookup) begin
        o_hit <= w_hit;
        if (w_hit) begin
          if (i_write_en_cache)
            r_dirty[i_index][w_hit_way] <= 1'b1;
          o_data_out <= i_write_en_cache ? i_data_in : w_hit_word;
          o_dirty_bit       <= 1'b0;
          o_dirty_block_out <= '0;
          o_victim_tag      <= '0;
        end else begin
          r_victim_way_q <= w_victim;
          r_pending_q    <= 1'b1;
          o_data_out     <= '0;
          o_dirty_bit    <= r_valid[i_index][w_victim] &
                            r_dirty[i_index][w_victim];
          o_dirty_block_out <= w_victim_blk;
          o_victim_tag      <= r_tag[i_index][w_victim];
        end
      end
    end
  end

  // Tag/data storage carries no reset; validity alone gates its use.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_fill) begin
        r_tag[i_index][r_victim_way_q] <= i_tag;
        for (int k = 0; k < WORDS_PER_BLK; k++)
          r_data[i_index][r_victim_way_q][k] <=
            (w_merge && OFFSET_W'(k) == i_blk_offset) ?
            i_data_in : i_data_in_mem[32*k +: 32];
      end else if (w_lookup && w_hit && i_write_en_cache) begin
        r_data[i_index][w_hit_way][i_blk_offset] <= i_data_in;
      end
    end
  end

endmodule

// File: tb/tb_cache_memory_nway.sv
// Directed bench for cache_memory_nway (64 sets, 2 ways, 4 words).
// Inputs change on negedge; registered outputs sampled on the next negedge.
module tb_cache_memory_nway;

  logic         clk = 1'b0;
  logic         rst;
  logic [23:0]  tag;
  logic [5:0]   index;
  logic [1:0]   blk_offset;
  logic         req_type;
  logic         read_en_cache;
  logic         write_en_cache;
  logic         refill;
  logic [127:0] data_in_mem;
  logic [31:0]  data_in;
  logic         resp_valid;
  logic         hit;
  logic [31:0]  data_out;
  logic         dirty_bit;
  logic [127:0] dirty_block_out;
  logic [23:0]  victim_tag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_memory_nway dut (
    .clk               (clk),
    .rst               (rst),
    .i_tag             (tag),
    .i_index           (index),
    .i_blk_offset      (blk_offset),
    .i_req_type        (req_type),
    .i_read_en_cache   (read_en_cache),
    .i_write_en_cache  (write_en_cache),
    .i_refill          (refill),
    .i_data_in_mem     (data_in_mem),
    .i_data_in         (data_in),
    .o_resp_valid      (resp_valid),
    .o_hit             (hit),
    .o_data_out        (data_out),
    .o_dirty_bit       (dirty_bit),
    .o_dirty_block_out (dirty_block_out),
    .o_victim_tag      (victim_tag)
  );

  task automatic lookup(input logic wr, input logic [23:0] t,
                        input logic [5:0] idx, input logic [1:0] off,
                        input logic [31:0] d);
    @(negedge clk);
    tag = t; index = idx; blk_offset = off; data_in = d;
    req_type = wr; read_en_cache = ~wr; write_en_cache = wr;
    refill = 1'b0;
    @(negedge clk);
    read_en_cache = 1'b0; write_en_cache = 1'b0;
  endtask

  task automatic do_refill(input logic rt, input logic [23:0] t,
                           input logic [5:0] idx, input logic [1:0] off,
                           input logic [31:0] d, input logic [127:0] blk);
    @(negedge clk);
    tag = t; index = idx; blk_offset = off; data_in = d;
    req_type = rt; data_in_mem = blk;
    write_en_cache = 1'b1; refill = 1'b1; read_en_cache = 1'b0;
    @(negedge clk);
    write_en_cache = 1'b0; refill = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tag = '0; index = '0; blk_offset = '0; req_type = 1'b0;
    read_en_cache = 1'b0; write_en_cache = 1'b0; refill = 1'b0;
    data_in_mem = '0; data_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks += 5;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid);
    end
    if (hit !== 1'b0) begin
      errors++; $display("FAIL reset_hit got=%b exp=0", hit);
    end
    if (data_out !== 32'h0) begin
      errors++; $display("FAIL reset_data_out got=%h exp=0", data_out);
    end
    if (dirty_bit !== 1'b0) begin
      errors++; $display("FAIL reset_dirty_bit got=%b exp=0", dirty_bit);
    end
    if (victim_tag !== 24'h0) begin
      errors++; $display("FAIL reset_victim_tag got=%h exp=0", victim_tag);
    end
  endtask

  task automatic test_read_miss;
    lookup(1'b0, 24'hABCDE0, 6'd0, 2'd3, 32'h0);
    checks += 3;
    if (resp_valid !== 1'b1) begin
      errors++; $display("FAIL miss_resp_valid got=%b exp=1", resp_valid);
    end
    if (hit !== 1'b0) begin
      errors++; $display("FAIL miss_hit got=%b exp=0", hit);
    end
    if (dirty_bit !== 1'b0) begin
      errors++; $display("FAIL miss_dirty got=%b exp=0", dirty_bit);
    end
  endtask

  task automatic test_refill_read;
    do_refill(1'b0, 24'hABCDE0, 6'd0, 2'd0, 32'h0,
              {32'hDEADBEEF, 32'h22220002, 32'h11110001, 32'h00000000});
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL refill_no_resp got=%b exp=0", resp_valid);
    end
    lookup(1'b0, 24'hABCDE0, 6'd0, 2'd3, 32'h0);
    checks += 2;
    if (hit !== 1'b1) begin
      errors++; $display("FAIL refill_read_hit got=%b exp=1", hit);
    end
    if (data_out !== 32'hDEADBEEF) begin
      errors++; $display("FAIL refill_read_w3 got=%h exp=deadbeef", data_out);
    end
    lookup(1'b0, 24'hABCDE0, 6'd0, 2'd2, 32'h0);
    checks++;
    if (data_out !== 32'h22220002) begin
      errors++; $display("FAIL refill_read_w2 got=%h exp=22220002", data_out);
    end
  endtask

  task automatic test_write_hit;
    lookup(1'b1, 24'hABCDE0, 6'd0, 2'd1, 32'hCAFEBABE);
    checks++;
    if (hit !== 1'b1) begin
      errors++; $display("FAIL write_hit got=%b exp=1", hit);
    end
    lookup(1'b0, 24'hABCDE0, 6'd0, 2'd1, 32'h0);
    checks++;
    if (data_out !== 32'hCAFEBABE) begin
      errors++; $display("FAIL write_readback got=%h exp=cafebabe", data_out);
    end
  endtask

  task automatic test_eviction;
    lookup(1'b0, 24'h000ABC, 6'd0, 2'd0, 32'h0);
    checks += 2;
    if (hit !== 1'b0) begin
      errors++; $display("FAIL fill1_miss got=%b exp=0", hit);
    end
    if (dirty_bit !== 1'b0) begin
      errors++; $display("FAIL fill1_dirty got=%b exp=0", dirty_bit);
    end
    do_refill(1'b0, 24'h000ABC, 6'd0, 2'd0, 32'h0,
              {32'h0000B003, 32'h0000B002, 32'h0000B001, 32'h0000B000});
    lookup(1'b0, 24'h000ABC, 6'd0, 2'd2, 32'h0);
    checks += 2;
    if (hit !== 1'b1) begin
      errors++; $display("FAIL way1_hit got=%b exp=1", hit);
    end
    if (data_out !== 32'h0000B002) begin
      errors++; $display("FAIL way1_data got=%h exp=0000b002", data_out);
    end
    lookup(1'b0, 24'h111111, 6'd0, 2'd0, 32'h0);
    checks += 5;
    if (hit !== 1'b0) begin
      errors++; $display("FAIL evict_hit got=%b exp=0", hit);
    end
    if (dirty_bit !== 1'b1) begin
      errors++; $display("FAIL evict_dirty got=%b exp=1", dirty_bit);
    end
    if (victim_tag !== 24'hABCDE0) begin
      errors++; $display("FAIL evict_tag got=%h exp=abcde0", victim_tag);
    end
    if (dirty_block_out[63:32] !== 32'hCAFEBABE) begin
      errors++;
      $display("FAIL evict_w1 got=%h exp=cafebabe", dirty_block_out[63:32]);
    end
    if (dirty_block_out[127:96] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL evict_w3 got=%h exp=deadbeef", dirty_block_out[127:96]);
    end
  endtask

  task automatic test_write_miss;
    lookup(1'b1, 24'h000044, 6'd4, 2'd0, 32'h12345678);
    checks++;
    if (hit !== 1'b0) begin
      errors++; $display("FAIL wmiss_hit got=%b exp=0", hit);
    end
    do_refill(1'b1, 24'h000044, 6'd4, 2'd0, 32'h12345678,
              {4{32'hA5A5A5A5}});
    lookup(1'b0, 24'h000044, 6'd4, 2'd0, 32'h0);
    checks += 2;
    if (hit !== 1'b1) begin
      errors++; $display("FAIL merge_hit got=%b exp=1", hit);
    end
    if (data_out !== 32'h12345678) begin
      errors++; $display("FAIL merge_w0 got=%h exp=12345678", data_out);
    end
    lookup(1'b0, 24'h000044, 6'd4, 2'd2, 32'h0);
    checks++;
    if (data_out !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL merge_w2 got=%h exp=a5a5a5a5", data_out);
    end
    lookup(1'b0, 24'h000055, 6'd4, 2'd0, 32'h0);
    checks++;
    if (dirty_bit !== 1'b0) begin
      errors++; $display("FAIL idx4_way1_dirty got=%b exp=0", dirty_bit);
    end
    do_refill(1'b0, 24'h000055, 6'd4, 2'd0, 32'h0, '0);
    lookup(1'b0, 24'h000066, 6'd4, 2'd0, 32'h0);
    checks += 3;
    if (dirty_bit !== 1'b1) begin
      errors++; $display("FAIL merge_dirty got=%b exp=1", dirty_bit);
    end
    if (victim_tag !== 24'h000044) begin
      errors++; $display("FAIL merge_vtag got=%h exp=000044", victim_tag);
    end
    if (dirty_block_out[31:0] !== 32'h12345678) begin
      errors++;
      $display("FAIL merge_vblk got=%h exp=12345678", dirty_block_out[31:0]);
    end
    do_refill(1'b0, 24'h000066, 6'd4, 2'd0, 32'h0, '0);
  endtask

  task automatic test_stray_refill;
    do_refill(1'b0, 24'h000088, 6'd8, 2'd0, 32'h0, {4{32'h88888888}});
    lookup(1'b0, 24'h000088, 6'd8, 2'd0, 32'h0);
    checks++;
    if (hit !== 1'b0) begin
      errors++; $display("FAIL stray_refill_hit got=%b exp=0", hit);
    end
  endtask

  task automatic test_reset_mid_refill;
    lookup(1'b0, 24'h00000C, 6'd12, 2'd0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    tag = 24'h00000C; index = 6'd12; data_in_mem = {4{32'hC0C0C0C0}};
    write_en_cache = 1'b1; refill = 1'b1; req_type = 1'b1;
    @(negedge clk);
    rst = 1'b0; write_en_cache = 1'b0; refill = 1'b0;
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_resp got=%b exp=0", resp_valid);
    end
    lookup(1'b0, 24'h00000C, 6'd12, 2'd0, 32'h0);
    checks += 3;
    if (resp_valid !== 1'b1) begin
      errors++; $display("FAIL rst_mid_lookup_valid got=%b exp=1", resp_valid);
    end
    if (hit !== 1'b0) begin
      errors++; $display("FAIL rst_mid_hit got=%b exp=0", hit);
    end
    if (dirty_bit !== 1'b0) begin
      errors++; $display("FAIL rst_mid_dirty got=%b exp=0", dirty_bit);
    end
    lookup(1'b0, 24'hABCDE0, 6'd0, 2'd0, 32'h0);
    checks++;
    if (hit !== 1'b0) begin
      errors++; $display("FAIL rst_cleared_idx0 got=%b exp=0", hit);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_miss();
    test_refill_read();
    test_write_hit();
    test_eviction();
    test_write_miss();
    test_stray_refill();
    test_reset_mid_refill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
